// File: rtl/synchronizer_nff_filt.sv
// +----------------------------------------------------------------------------+
// | Module   : synchronizer_nff_filt                                           |
// | Purpose  : Multi-bit N-stage synchronizer with an optional per-bit glitch  |
// |            filter and per-bit rise/fall pulses on the filtered level.      |
// |            Every bit is handled independently; correlated multi-bit data  |
// |            must be Gray-coded by the sender.                              |
// | Macro    : SYNC_GLITCH_FILTER_EN - when defined, data_filt_o only follows  |
// |            data_sync_o after FILTER_CYCLES consecutive cycles of the new   |
// |            value. When undefined, data_filt_o = data_sync_o.               |
// | Ports    : clk_i        - single clock, rising edge                        |
// |            rst_i        - synchronous active-high reset                    |
// |            data_i       - asynchronous input bits                          |
// |            data_sync_o  - last synchronizer stage                          |
// |            data_filt_o  - filtered (debounced) level                       |
// |            rise_o       - one-cycle pulse on 0->1 of data_filt_o           |
// |            fall_o       - one-cycle pulse on 1->0 of data_filt_o           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module synchronizer_nff_filt #(
  parameter int                    DATA_WIDTH    = 1,
  parameter int                    STAGES        = 2,
  parameter int                    FILTER_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_sync_o,
  output logic [DATA_WIDTH-1:0] data_filt_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o
);

  // Elaboration-time parameter checks.
  generate
    if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
      $error("synchronizer_nff_filt: STAGES must be in 2..8");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("synchronizer_nff_filt: FILTER_CYCLES must be >= 1");
    end
  endgenerate

  // Synchronizer chain: plain flop-to-flop, nothing between stages.
  logic [DATA_WIDTH-1:0] sync [STAGES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        sync[i] <= RESET_VALUE;
      end
    end else begin
      sync[0] <= data_i;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign data_sync_o = sync[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
  localparam int              CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0]      cnt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] filt_q;

  // A differing value must be seen FILTER_CYCLES times in a row; any return
  // to the held value restarts the count. cnt saturates at CNT_LAST because
  // reaching it either commits the new value or is cleared by a match.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= RESET_VALUE;
      for (int b = 0; b < DATA_WIDTH; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < DATA_WIDTH; b++) begin
        if (data_sync_o[b] != filt_q[b]) begin
          if (cnt[b] == CNT_LAST) begin
            filt_q[b] <= data_sync_o[b];
            cnt[b]    <= '0;
          end else begin
            cnt[b] <= cnt[b] + CNT_W'(1);
          end
        end else begin
          cnt[b] <= '0;
        end
      end
    end
  end

  assign data_filt_o = filt_q;
`else
  assign data_filt_o = data_sync_o;
`endif

  // Edge history; pulses are decoded from registers only.
  logic [DATA_WIDTH-1:0] filt_d1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_d1 <= RESET_VALUE;
    end else begin
      filt_d1 <= data_filt_o;
    end
  end

  assign rise_o = data_filt_o & ~filt_d1;
  assign fall_o = ~data_filt_o & filt_d1;

endmodule

`default_nettype wire

// File: tb/tb_synchronizer_nff_filt.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_synchronizer_nff_filt                                        |
// | Purpose  : Directed self-checking bench for synchronizer_nff_filt. Two     |
// |            instances: a 4-bit, 3-stage, 4-cycle-filter unit with reset     |
// |            value 0, and a 1-bit, 2-stage, 1-cycle-filter unit with reset   |
// |            value 1. Expectations follow SYNC_GLITCH_FILTER_EN.             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_synchronizer_nff_filt;

`ifdef SYNC_GLITCH_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  // Cycles from the sampling edge until data_filt_o moves.
  localparam int LAT  = FILT_EN ? 7 : 3;  // 3 stages (+4 filter)
  localparam int LAT2 = FILT_EN ? 3 : 2;  // 2 stages (+1 filter)

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic [3:0] sync_o, filt_o, rise_o, fall_o;
  logic       data2;
  logic       sync2_o, filt2_o, rise2_o, fall2_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  synchronizer_nff_filt #(
    .DATA_WIDTH(4), .STAGES(3), .FILTER_CYCLES(4), .RESET_VALUE(4'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data),
    .data_sync_o(sync_o), .data_filt_o(filt_o), .rise_o(rise_o), .fall_o(fall_o)
  );

  synchronizer_nff_filt #(
    .DATA_WIDTH(1), .STAGES(2), .FILTER_CYCLES(1), .RESET_VALUE(1'b1)
  ) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data2),
    .data_sync_o(sync2_o), .data_filt_o(filt2_o), .rise_o(rise2_o), .fall_o(fall2_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int nrise, nfall, rise_at, fall_at, other;

    // Reset held 3 cycles with data high: outputs sit at the reset value.
    rst   = 1'b1;
    data  = 4'hF;
    data2 = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      tick();
      chk("rst_sync",  {28'd0, sync_o}, 32'h0);
      chk("rst_filt",  {28'd0, filt_o}, 32'h0);
      chk("rst_edges", {24'd0, rise_o, fall_o}, 32'h0);
      chk("rst2_lvl",  {30'd0, sync2_o, filt2_o}, 32'h3);
      chk("rst2_edges", {30'd0, rise2_o, fall2_o}, 32'h0);
    end

    // Release with inputs equal to reset values: no pulses at all.
    rst   = 1'b0;
    data  = 4'h0;
    data2 = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("rel_edges",  {24'd0, rise_o, fall_o}, 32'h0);
      chk("rel_filt",   {28'd0, filt_o}, 32'h0);
      chk("rel2_edges", {30'd0, rise2_o, fall2_o}, 32'h0);
      chk("rel2_filt",  {31'd0, filt2_o}, 32'h1);
    end

    // Latency: 0x0 -> 0x5 sampled at tick 1.
    data = 4'h5;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk("lat_sync", {28'd0, sync_o}, (t >= 3)   ? 32'h5 : 32'h0);
      chk("lat_filt", {28'd0, filt_o}, (t >= LAT) ? 32'h5 : 32'h0);
      chk("lat_rise", {28'd0, rise_o}, (t == LAT) ? 32'h5 : 32'h0);
      chk("lat_fall", {28'd0, fall_o}, 32'h0);
    end

    // Bit-1 pulses of 3 and 4 cycles on top of 0x5.
    for (int p = 3; p <= 4; p++) begin
      nrise = 0; nfall = 0; rise_at = -1; fall_at = -1; other = 0;
      data = 4'h7;
      for (int t = 1; t <= 16; t++) begin
        tick();
        if (rise_o[1]) begin nrise++; rise_at = t; end
        if (fall_o[1]) begin nfall++; fall_at = t; end
        if (((rise_o | fall_o) & 4'b1101) != 4'b0) other++;
        if (t == p) data = 4'h5;
      end
      if (FILT_EN) begin
        chk("glitch_nrise",   nrise,   (p == 4) ? 1 : 0);
        chk("glitch_nfall",   nfall,   (p == 4) ? 1 : 0);
        chk("glitch_rise_at", rise_at, (p == 4) ? 7 : -1);
        chk("glitch_fall_at", fall_at, (p == 4) ? 11 : -1);
      end else begin
        chk("glitch_nrise",   nrise,   1);
        chk("glitch_nfall",   nfall,   1);
        chk("glitch_rise_at", rise_at, 3);
        chk("glitch_fall_at", fall_at, p + 3);
      end
      chk("glitch_other", other, 0);
      chk("glitch_final", {28'd0, filt_o}, 32'h5);
    end

    // Second unit: 1 -> 0 then 0 -> 1.
    data2 = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("u2_fall_sync", {31'd0, sync2_o}, (t >= 2)    ? 32'h0 : 32'h1);
      chk("u2_fall_filt", {31'd0, filt2_o}, (t >= LAT2) ? 32'h0 : 32'h1);
      chk("u2_fall_pls",  {30'd0, rise2_o, fall2_o}, (t == LAT2) ? 32'h1 : 32'h0);
    end
    data2 = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      chk("u2_rise_filt", {31'd0, filt2_o}, (t >= LAT2) ? 32'h1 : 32'h0);
      chk("u2_rise_pls",  {30'd0, rise2_o, fall2_o}, (t == LAT2) ? 32'h2 : 32'h0);
    end

    // Reset while bit 3 is pending 0 -> 1 (counter at 2 with the filter).
    data = 4'hD;
    for (int t = 1; t <= 5; t++) tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_sync",  {28'd0, sync_o}, 32'h0);
    chk("mid_rst_filt",  {28'd0, filt_o}, 32'h0);
    chk("mid_rst_edges", {24'd0, rise_o, fall_o}, 32'h0);
    chk("mid_rst_u2",    {31'd0, filt2_o}, 32'h1);
    rst = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk("post_sync", {28'd0, sync_o}, (t >= 3)   ? 32'hD : 32'h0);
      chk("post_filt", {28'd0, filt_o}, (t >= LAT) ? 32'hD : 32'h0);
      chk("post_rise", {28'd0, rise_o}, (t == LAT) ? 32'hD : 32'h0);
      chk("post_fall", {28'd0, fall_o}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
